// File: rtl/float_pkg.sv
// IEEE-754 single-precision field constants and parameter legality helpers
// shared by the integer-to-float datapath.
package float_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  localparam int IN_W_MIN = 2;
  localparam int IN_W_MAX = MANT_W + 1;
  localparam int FRAC_MAX = 126;

  // Widths above MANT_W+1 would need rounding; FRAC above 126 could underflow.
  function automatic bit in_w_legal(input int w);
    return (w >= IN_W_MIN) && (w <= IN_W_MAX);
  endfunction

  function automatic bit frac_legal(input int f);
    return (f >= 0) && (f <= FRAC_MAX);
  endfunction

endpackage

// File: rtl/int_to_float_pipe_if.sv
// Sample-in / float-out bundle for the ADC int-to-float converter.
interface int_to_float_pipe_if #(
  parameter int IN_W = 16,
  parameter int CH_W = 3
);
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic [CH_W-1:0] in_chan;
  logic            offset_bin;
  logic            out_valid;
  logic [31:0]     out_float;
  logic [CH_W-1:0] out_chan;
  logic [31:0]     sample_cnt;

  modport master (
    output in_valid, in_data, in_chan, offset_bin,
    input  out_valid, out_float, out_chan, sample_cnt
  );

  modport slave (
    input  in_valid, in_data, in_chan, offset_bin,
    output out_valid, out_float, out_chan, sample_cnt
  );
endinterface

// File: rtl/lzc_prio.sv
// Priority leading-one detector: reports the index of the highest set bit
// and a zero flag when no bit is set.
module lzc_prio #(
  parameter int W  = 16,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  data,
  output logic [PW-1:0] pos,
  output logic          zero
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (data[i]) pos = PW'(i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage integer (two's complement or offset binary) to IEEE single
// converter with a channel tag riding alongside; no backpressure.
module int_to_float_pipe
  import float_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int CH_W = 3,
  parameter int FRAC = 0
) (
  input logic clk,
  input logic rst_n,
  int_to_float_pipe_if.slave io
);

  localparam int STAGES = 3;
  localparam int PW     = $clog2(IN_W);
  localparam int FW     = IN_W - 1;

  generate
    if (!in_w_legal(IN_W)) begin : g_bad_in_w
      $error("int_to_float_pipe: IN_W must be in 2..24");
    end
    if (!frac_legal(FRAC)) begin : g_bad_frac
      $error("int_to_float_pipe: FRAC must be in 0..126");
    end
  endgenerate

  typedef struct packed {
    logic            sign;
    logic [IN_W-1:0] mag;
    logic [CH_W-1:0] chan;
  } s1_t;

  typedef struct packed {
    s1_t           d;
    logic [PW-1:0] pos;
    logic          zero;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [IN_W-1:0] x;
  logic [PW-1:0]   lz_pos;
  logic            lz_zero;
  logic [PW-1:0]   sh;
  logic [FW-1:0]   frac_bits;
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  expo;
  logic [31:0]     float_d;

  assign vld_pipe[0] = io.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // S1: mode fix-up and sign/magnitude split. The most negative code negates
  // to itself, which read as unsigned is exactly the wanted magnitude.
  always_comb begin
    x         = io.in_data ^ {io.offset_bin, {(IN_W-1){1'b0}}};
    s1_d.sign = x[IN_W-1];
    s1_d.mag  = x[IN_W-1] ? (~x + IN_W'(1)) : x;
    s1_d.chan = io.in_chan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              s1_q <= '0;
    else if (vld_pipe[0])    s1_q <= s1_d;
  end

  // S2: leading-one position
  lzc_prio #(.W(IN_W), .PW(PW)) u_lzc (
    .data (s1_q.mag),
    .pos  (lz_pos),
    .zero (lz_zero)
  );

  always_comb begin
    s2_d.d    = s1_q;
    s2_d.pos  = lz_pos;
    s2_d.zero = lz_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              s2_q <= '0;
    else if (vld_pipe[1])    s2_q <= s2_d;
  end

  // S3: normalise so the leading one drops off the top; the remaining bits
  // are the mantissa, left-aligned and zero-padded.
  always_comb begin
    sh        = PW'(IN_W - 1) - s2_q.pos;
    frac_bits = FW'(s2_q.d.mag << sh);
    mant      = MANT_W'({frac_bits, {MANT_W{1'b0}}} >> FW);
    expo      = EXP_W'(EXP_BIAS + int'(s2_q.pos) - FRAC);
    float_d   = s2_q.zero ? 32'h0000_0000 : {s2_q.d.sign, expo, mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_float  <= '0;
      io.out_chan   <= '0;
      io.sample_cnt <= '0;
    end else if (vld_pipe[2]) begin
      io.out_float  <= float_d;
      io.out_chan   <= s2_q.d.chan;
      io.sample_cnt <= io.sample_cnt + 32'd1;
    end
  end

  assign io.out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Scoreboard bench: stimulus pushes hand-computed floats with due cycles,
// negedge monitors pop and compare against both converter instances.
module tb_int_to_float_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_to_float_pipe_if #(.IN_W(16), .CH_W(3)) ifa ();
  int_to_float_pipe_if #(.IN_W(16), .CH_W(3)) ifb ();

  int_to_float_pipe #(.IN_W(16), .CH_W(3), .FRAC(0)) u_a (
    .clk(clk), .rst_n(rst_n), .io(ifa));
  int_to_float_pipe #(.IN_W(16), .CH_W(3), .FRAC(15)) u_b (
    .clk(clk), .rst_n(rst_n), .io(ifb));

  typedef struct {
    logic [31:0] f;
    logic [2:0]  ch;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          cnt_exp[2];
  logic [31:0] last_f[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic [31:0] f,
                     input logic [2:0] ch, input logic [31:0] cnt);
    exp_t e;
    int   qs;
    qs = (w == 0) ? q0.size() : q1.size();
    if (v) begin
      if (qs == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid dut%0d: got out_valid=1 want 0 (cycle %0d)", w, cyc);
      end else begin
        if (w == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk("float", f, e.f);
        chk("chan", {29'b0, ch}, {29'b0, e.ch});
        chk("latency", 32'(cyc), 32'(e.due));
        cnt_exp[w]++;
        chk("sample_cnt", cnt, 32'(cnt_exp[w]));
        last_f[w] = e.f;
      end
    end else begin
      chk("hold_float", f, last_f[w]);
      if (qs != 0) begin
        if (w == 0) e = q0[0]; else e = q1[0];
        if (e.due < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL missing_valid dut%0d: got none want %h due cycle %0d", w, e.f, e.due);
          if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ifa.out_valid, ifa.out_float, ifa.out_chan, ifa.sample_cnt);
      mon(1, ifb.out_valid, ifb.out_float, ifb.out_chan, ifb.sample_cnt);
    end
  end

  task automatic drop_valid();
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  task automatic send(input int w, input logic [15:0] d, input logic ob,
                      input logic [2:0] ch, input logic [31:0] ef);
    exp_t e;
    @(posedge clk); #1;
    drop_valid();
    if (w == 0) begin
      ifa.in_valid = 1'b1; ifa.in_data = d; ifa.offset_bin = ob; ifa.in_chan = ch;
    end else begin
      ifb.in_valid = 1'b1; ifb.in_data = d; ifb.offset_bin = ob; ifb.in_chan = ch;
    end
    e.f = ef; e.ch = ch; e.due = cyc + 3;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drop_valid();
    end
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete();
    cnt_exp[0] = 0; cnt_exp[1] = 0;
    last_f[0] = '0; last_f[1] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, ifa.out_valid}, 32'd0);
    chk({tag, "_float"}, ifa.out_float, 32'd0);
    chk({tag, "_chan"}, {29'b0, ifa.out_chan}, 32'd0);
    chk({tag, "_cnt"}, ifa.sample_cnt, 32'd0);
  endtask

  logic [31:0] tag_exp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  int gaps [8] = '{0, 2, 1, 0, 3, 0, 1, 2};

  initial begin
    clear_model();
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_chan = '0; ifa.offset_bin = 0;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.in_chan = '0; ifb.offset_bin = 0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // back-to-back basics
    send(0, 16'd125, 0, 3'd1, 32'h42FA0000);
    send(0, 16'd120, 0, 3'd2, 32'h42F00000);
    // edge codes
    send(0, 16'h0000, 0, 3'd3, 32'h00000000);
    send(0, 16'hFFFF, 0, 3'd4, 32'hBF800000);
    send(0, 16'h7FFF, 0, 3'd5, 32'h46FFFE00);
    send(0, 16'h8000, 0, 3'd6, 32'hC7000000);
    idle(2);
    // offset binary
    send(0, 16'h8000, 1, 3'd0, 32'h00000000);
    send(0, 16'h0000, 1, 3'd1, 32'hC7000000);
    send(0, 16'hFFFF, 1, 3'd2, 32'h46FFFE00);
    for (int i = 0; i < 4; i++) begin
      send(0, 16'h8000, 1, 3'(i), 32'h00000000);
      send(0, 16'h8000, 0, 3'(i), 32'hC7000000);
    end
    idle(1);
    // FRAC=15 scaling on the second instance
    send(1, 16'h4000, 0, 3'd5, 32'h3F000000);
    send(1, 16'hC000, 0, 3'd6, 32'hBF000000);
    idle(6);

    // fresh count for the tag/bubble run
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(0, 16'(i + 1), 0, 3'(i), tag_exp[i]);
      idle(gaps[i]);
    end
    idle(6);
    chk("cnt_after_tags", ifa.sample_cnt, 32'd8);

    // reset with two samples in flight
    send(0, 16'd125, 0, 3'd3, 32'h42FA0000);
    send(0, 16'hFFFF, 0, 3'd4, 32'hBF800000);
    @(posedge clk); #3;
    drop_valid();
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    send(0, 16'd120, 0, 3'd7, 32'h42F00000);
    idle(6);

    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending want 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
